// File: rtl/l1_fill_unit.sv
// l1_fill_unit: services L1 cache misses by reading block data from the
// chunk memory. Misses from N ports are arbitrated round-robin; one miss is
// in flight at a time. Out-of-range positions are answered with BLOCK_AIR
// without touching memory.
//
// Ports:
//   clk_in      - clock, rising-edge
//   rst_in      - asynchronous active-high reset
//   miss_valid  - per-port miss request
//   miss_pos    - per-port requested block position
//   miss_ready  - per-port grant (one-hot or zero, IDLE only)
//   fill_valid  - fill response present
//   fill_ready  - fill accepted by the cache
//   fill_port   - index of the port being filled
//   fill_pos    - position tag of the fill
//   fill_block  - block data of the fill
//   mem_en      - chunk-memory read enable (ISSUE only)
//   mem_addr    - chunk-memory address {z, y, x}
//   mem_data    - chunk-memory read data, RD_LAT cycles after mem_en
//   busy        - unit is handling a miss

`ifndef CHUNK_WIDTH
`define CHUNK_WIDTH 16
`endif

package l1_fill_pkg;
    localparam int W  = `CHUNK_WIDTH;
    localparam int LW = $clog2(W);
    localparam int PW = LW + 1;

    typedef logic signed [PW-1:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } BlockPos;
    typedef logic [7:0] BlockType;

    localparam BlockType BLOCK_AIR = 8'd0;
endpackage

module l1_fill_unit
    import l1_fill_pkg::*;
#(
    parameter int N      = 4,
    parameter int RD_LAT = 2,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [N-1:0]      miss_valid,
    input  BlockPos [N-1:0]   miss_pos,
    output logic [N-1:0]      miss_ready,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [IW-1:0]     fill_port,
    output BlockPos           fill_pos,
    output BlockType          fill_block,
    output logic              mem_en,
    output logic [3*LW-1:0]   mem_addr,
    input  BlockType          mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} state_t;

    state_t        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] port_q;
    BlockPos       pos_q;
    BlockType      block_q;
    logic [2:0]    cnt_q;

    logic          grant;
    logic [IW-1:0] grant_idx;

    // A coordinate is in range when it lies in 0..W-1, i.e. every bit from
    // LW up to the sign bit is clear.
    function automatic logic in_range(input BlockPos p);
        return (p.x[PW-1:LW] == '0) && (p.y[PW-1:LW] == '0) && (p.z[PW-1:LW] == '0);
    endfunction

    // Round-robin search starting at rr_ptr_q; first valid port wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!grant && miss_valid[idx]) begin
                grant     = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        miss_ready = '0;
        // The rst_in term keeps the grant off while reset is asserted, since
        // state_q already reads IDLE during reset.
        if (state_q == IDLE && grant && !rst_in)
            miss_ready[grant_idx] = 1'b1;
    end

    assign busy       = (state_q != IDLE);
    assign fill_valid = (state_q == FILL);
    assign mem_en     = (state_q == ISSUE);
    assign mem_addr   = {pos_q.z[LW-1:0], pos_q.y[LW-1:0], pos_q.x[LW-1:0]};
    assign fill_port  = port_q;
    assign fill_pos   = pos_q;
    assign fill_block = block_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            port_q   <= '0;
            pos_q    <= '0;
            block_q  <= BLOCK_AIR;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        port_q   <= grant_idx;
                        pos_q    <= miss_pos[grant_idx];
                        rr_ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
                        cnt_q    <= '0;
                        if (in_range(miss_pos[grant_idx])) begin
                            state_q <= ISSUE;
                        end else begin
                            block_q <= BLOCK_AIR;
                            state_q <= FILL;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Read data is valid in the RD_LAT-th WAIT cycle.
                    if (cnt_q == 3'(RD_LAT - 1)) begin
                        block_q <= mem_data;
                        state_q <= FILL;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                FILL: begin
                    if (fill_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_fill_unit.sv
module tb_l1_fill_unit;
    import l1_fill_pkg::*;

    localparam int N      = 4;
    localparam int RD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     miss_valid = '0;
    BlockPos [N-1:0]  miss_pos = '0;
    logic [N-1:0]     miss_ready;
    logic             fill_valid;
    logic             fill_ready = 1'b1;
    logic [1:0]       fill_port;
    BlockPos          fill_pos;
    BlockType         fill_block;
    logic             mem_en;
    logic [3*LW-1:0]  mem_addr;
    BlockType         mem_data;
    logic             busy;

    BlockType mem_value = 8'h00;
    logic     pv1 = 1'b0, pv2 = 1'b0;
    int       memen_cnt = 0;
    int       total = 0;
    int       bad = 0;

    l1_fill_unit #(.N(N), .RD_LAT(RD_LAT)) dut (
        .clk_in(clk), .rst_in(rst),
        .miss_valid(miss_valid), .miss_pos(miss_pos), .miss_ready(miss_ready),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_port(fill_port),
        .fill_pos(fill_pos), .fill_block(fill_block),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Chunk memory: data valid exactly RD_LAT (=2) cycles after mem_en,
    // garbage in every other cycle.
    always @(posedge clk) begin
        pv1 <= mem_en;
        pv2 <= pv1;
        if (mem_en) memen_cnt <= memen_cnt + 1;
    end
    assign mem_data = pv2 ? mem_value : 8'hEE;

    function automatic BlockPos mkpos(input int x, input int y, input int z);
        BlockPos p;
        p.x = coord_t'(x);
        p.y = coord_t'(y);
        p.z = coord_t'(z);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        miss_valid = 4'hF;
        tick();
        tick();
        total++; if (miss_ready !== 4'b0000) begin bad++; $display("FAIL rst_miss_ready got=%b want=0000", miss_ready); end
        total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL rst_fill_valid got=%b want=0", fill_valid); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (fill_port !== 2'd0) begin bad++; $display("FAIL rst_fill_port got=%0d want=0", fill_port); end
        total++; if (fill_pos !== BlockPos'(0)) begin bad++; $display("FAIL rst_fill_pos got=%h want=0", fill_pos); end
        total++; if (fill_block !== BLOCK_AIR) begin bad++; $display("FAIL rst_fill_block got=%h want=%h", fill_block, BLOCK_AIR); end
        miss_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    // Port 2 at (3,1,0) then port 3 at (15,15,15); rr_ptr starts at 0.
    task automatic test_in_range();
        int       ports [2] = '{2, 3};
        BlockPos  poss  [2];
        BlockType vals  [2] = '{8'h05, 8'hA7};
        logic [11:0] addrs [2] = '{12'h013, 12'hFFF};
        int base;
        poss[0] = mkpos(3, 1, 0);
        poss[1] = mkpos(15, 15, 15);
        fill_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_value = vals[i];
            miss_pos[ports[i]] = poss[i];
            miss_valid = 4'b1 << ports[i];
            #1;
            total++; if (miss_ready !== (4'b1 << ports[i])) begin bad++; $display("FAIL ir_grant got=%b want=%b", miss_ready, 4'b1 << ports[i]); end
            base = memen_cnt;
            tick(); // grant+1: ISSUE
            miss_valid = '0;
            total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL ir_mem_en got=%b want=1", mem_en); end
            total++; if (mem_addr !== addrs[i]) begin bad++; $display("FAIL ir_mem_addr got=%h want=%h", mem_addr, addrs[i]); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ir_busy got=%b want=1", busy); end
            tick(); // grant+2: WAIT
            total++; if (mem_en !== 1'b0 || fill_valid !== 1'b0) begin bad++; $display("FAIL ir_wait1 got=en%b/fv%b want=0/0", mem_en, fill_valid); end
            tick(); // grant+3: WAIT
            total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL ir_wait2 got=%b want=0", fill_valid); end
            tick(); // grant+4: FILL
            total++; if (fill_valid !== 1'b1) begin bad++; $display("FAIL ir_fill_valid got=%b want=1", fill_valid); end
            total++; if (fill_port !== 2'(ports[i])) begin bad++; $display("FAIL ir_fill_port got=%0d want=%0d", fill_port, ports[i]); end
            total++; if (fill_pos !== poss[i]) begin bad++; $display("FAIL ir_fill_pos got=%h want=%h", fill_pos, poss[i]); end
            total++; if (fill_block !== vals[i]) begin bad++; $display("FAIL ir_fill_block got=%h want=%h", fill_block, vals[i]); end
            tick(); // back in IDLE
            total++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ir_done got=fv%b/busy%b want=0/0", fill_valid, busy); end
            total++; if (memen_cnt - base !== 1) begin bad++; $display("FAIL ir_mem_en_count got=%0d want=1", memen_cnt - base); end
        end
    endtask

    // Port 0 at (-1,0,0) and at x=16 (wraps to the sign-bit pattern).
    task automatic test_out_of_range();
        BlockPos poss [2];
        int base;
        poss[0] = mkpos(-1, 0, 0);
        poss[1] = mkpos(16, 0, 0);
        mem_value = 8'h55;
        fill_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            miss_pos[0] = poss[i];
            miss_valid = 4'b0001;
            #1;
            total++; if (miss_ready !== 4'b0001) begin bad++; $display("FAIL oor_grant got=%b want=0001", miss_ready); end
            base = memen_cnt;
            tick(); // grant+1: FILL
            miss_valid = '0;
            total++; if (fill_valid !== 1'b1) begin bad++; $display("FAIL oor_fill_valid got=%b want=1", fill_valid); end
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL oor_mem_en got=%b want=0", mem_en); end
            total++; if (fill_block !== BLOCK_AIR) begin bad++; $display("FAIL oor_fill_block got=%h want=%h", fill_block, BLOCK_AIR); end
            total++; if (fill_pos !== poss[i] || fill_port !== 2'd0) begin bad++; $display("FAIL oor_fill_tag got=%h/%0d want=%h/0", fill_pos, fill_port, poss[i]); end
            tick();
            total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL oor_done got=%b want=0", fill_valid); end
            total++; if (memen_cnt != base) begin bad++; $display("FAIL oor_no_mem got=%0d want=0", memen_cnt - base); end
        end
    endtask

    task automatic test_round_robin();
        int wait_cnt;
        for (int p = 0; p < N; p++) miss_pos[p] = mkpos(-1, p, 0);
        rst = 1'b1;
        miss_valid = 4'hF;
        tick();
        total++; if (miss_ready !== 4'b0000) begin bad++; $display("FAIL rr_in_reset got=%b want=0000", miss_ready); end
        rst = 1'b0;
        #1;
        fill_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_cnt = 0;
            while (miss_ready == 4'b0000 && wait_cnt < 5) begin
                tick();
                wait_cnt++;
            end
            if (wait_cnt >= 5) begin
                total++; bad++;
                $display("FAIL rr_timeout got=no grant want=grant %0d", k % 4);
            end
            total++; if (miss_ready !== (4'b1 << (k % 4))) begin bad++; $display("FAIL rr_order got=%b want=%b", miss_ready, 4'b1 << (k % 4)); end
            tick();
            total++; if (fill_valid !== 1'b1 || fill_port !== 2'(k % 4)) begin bad++; $display("FAIL rr_fill got=fv%b/port%0d want=1/%0d", fill_valid, fill_port, k % 4); end
            tick();
        end
        miss_valid = '0;
        tick();
    endtask

    // rr_ptr is 0 on entry (8 grants in the previous test).
    task automatic test_back_pressure();
        BlockPos p2;
        p2 = mkpos(7, 8, 9);
        mem_value = 8'h3C;
        fill_ready = 1'b0;
        miss_pos[2] = p2;
        miss_pos[0] = mkpos(-1, -1, -1);
        miss_valid = 4'b0100;
        #1;
        total++; if (miss_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b want=0100", miss_ready); end
        tick();
        miss_valid = 4'b0001; // competing request must wait for the handshake
        tick();
        tick();
        tick(); // grant+4: FILL
        for (int c = 0; c < 5; c++) begin
            total++; if (fill_valid !== 1'b1 || fill_port !== 2'd2 || fill_pos !== p2 || fill_block !== 8'h3C)
                begin bad++; $display("FAIL bp_hold got=fv%b/port%0d/pos%h/blk%h want=1/2/%h/3c", fill_valid, fill_port, fill_pos, fill_block, p2); end
            total++; if (miss_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_grant got=%b want=0000", miss_ready); end
            tick();
        end
        fill_ready = 1'b1;
        #1;
        total++; if (fill_valid !== 1'b1 || miss_ready !== 4'b0000) begin bad++; $display("FAIL bp_accept got=fv%b/mr%b want=1/0000", fill_valid, miss_ready); end
        tick();
        total++; if (miss_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b want=0001", miss_ready); end
        tick();
        miss_valid = '0;
        total++; if (fill_valid !== 1'b1 || fill_port !== 2'd0 || fill_block !== BLOCK_AIR) begin bad++; $display("FAIL bp_next_fill got=fv%b/port%0d/blk%h want=1/0/00", fill_valid, fill_port, fill_block); end
        tick();
    endtask

    // rr_ptr is 1 on entry; port 1 is granted and the reset hits in WAIT.
    task automatic test_reset_wait();
        mem_value = 8'h33;
        fill_ready = 1'b1;
        miss_pos[1] = mkpos(2, 2, 2);
        miss_pos[0] = mkpos(-1, 0, 0);
        miss_pos[3] = mkpos(-1, 0, 3);
        miss_valid = 4'b0010;
        #1;
        total++; if (miss_ready !== 4'b0010) begin bad++; $display("FAIL rw_grant got=%b want=0010", miss_ready); end
        tick(); // ISSUE
        miss_valid = '0;
        tick(); // WAIT
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy_before got=%b want=1", busy); end
        #2;
        rst = 1'b1;
        miss_valid = 4'b1001;
        #1;
        total++; if (busy !== 1'b0 || mem_en !== 1'b0 || fill_valid !== 1'b0) begin bad++; $display("FAIL rw_async_ctrl got=busy%b/en%b/fv%b want=0/0/0", busy, mem_en, fill_valid); end
        total++; if (fill_port !== 2'd0 || fill_pos !== BlockPos'(0) || fill_block !== BLOCK_AIR) begin bad++; $display("FAIL rw_async_data got=%0d/%h/%h want=0/0/00", fill_port, fill_pos, fill_block); end
        total++; if (miss_ready !== 4'b0000) begin bad++; $display("FAIL rw_no_grant got=%b want=0000", miss_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        // rr_ptr back at 0 selects port 0 over port 3
        total++; if (miss_ready !== 4'b0001) begin bad++; $display("FAIL rw_rr_reset got=%b want=0001", miss_ready); end
        tick();
        miss_valid = '0;
        total++; if (fill_valid !== 1'b1 || fill_port !== 2'd0 || fill_block !== BLOCK_AIR) begin bad++; $display("FAIL rw_resume_fill got=fv%b/port%0d/blk%h want=1/0/00", fill_valid, fill_port, fill_block); end
        tick();
        total++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rw_idle got=fv%b/busy%b want=0/0", fill_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_in_range();
        test_out_of_range();
        test_round_robin();
        test_back_pressure();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_fill_unit.md
L1_FILL_UNIT -- requirements
Module: l1_fill_unit

Interface
REQ-001 SHALL have parameter N, default 4: number of L1 cache ports served.
REQ-002 SHALL have parameter RD_LAT, default 2: chunk-memory read latency in cycles, legal range 1..7.
REQ-003 SHALL take W = `CHUNK_WIDTH, a power of two. Coordinate width is PW = $clog2(W)+1, signed. LW = $clog2(W).
REQ-004 SHALL have port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port miss_valid, input, N: per-port miss request from l1_cache.
REQ-007 SHALL have port miss_pos, input, N x BlockPos: per-port requested block position (x, y, z, each PW bits).
REQ-008 SHALL have port miss_ready, output, N: per-port grant; one-hot or zero.
REQ-009 SHALL have port fill_valid, output, 1: fill response present.
REQ-010 SHALL have port fill_ready, input, 1: l1_cache accepts the fill.
REQ-011 SHALL have port fill_port, output, $clog2(N): index of the port being filled.
REQ-012 SHALL have port fill_pos, output, BlockPos: tag for the fill.
REQ-013 SHALL have port fill_block, output, BlockType: block data for the fill.
REQ-014 SHALL have port mem_en, output, 1: chunk-memory read enable.
REQ-015 SHALL have port mem_addr, output, 3*LW: chunk-memory address, {z[LW-1:0], y[LW-1:0], x[LW-1:0]}.
REQ-016 SHALL have port mem_data, input, BlockType: read data, valid RD_LAT cycles after the mem_en cycle.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and FILL.
REQ-019 SHALL compute miss_ready combinationally, nonzero only in IDLE: the first i with miss_valid[i]=1, searching from rr_ptr upward modulo N. A grant occurs in any IDLE cycle where some miss_valid bit is set.
REQ-020 SHALL, on a grant of port i, latch i and miss_pos[i], and update rr_ptr to (i+1) mod N.
REQ-021 SHALL treat a latched position as in-range iff each coordinate satisfies 0 <= c <= W-1 (sign bit 0 and bit LW clear).
REQ-022 SHALL, after a grant, move from IDLE to ISSUE if the position is in-range, or from IDLE to FILL with fill_block=BLOCK_AIR if not; no memory access is made for an out-of-range position.
REQ-023 SHALL, in ISSUE, hold for exactly 1 cycle with mem_en=1 and mem_addr driven from the latched position, then go to WAIT.
REQ-024 SHALL, in WAIT, count RD_LAT cycles, capture mem_data at the edge ending the RD_LAT-th WAIT cycle, then go to FILL.
REQ-025 SHALL hold mem_en=0 in every state except ISSUE. mem_addr SHALL be don't-care outside ISSUE.
REQ-026 SHALL, in FILL, drive fill_valid=1 with fill_port, fill_pos and fill_block stable until fill_ready=1 is sampled, then go to IDLE.
REQ-027 SHALL ignore miss_valid outside IDLE. A requester SHALL hold its miss_valid and miss_pos until granted.
REQ-028 SHALL give the following latency from a grant edge t when fill_ready is held at 1: in-range fill_valid appears in cycle t+2+RD_LAT (t+4 at default); out-of-range fill_valid appears in cycle t+1.
REQ-029 SHALL allow at most one outstanding miss. A new grant can occur no earlier than the cycle after the fill handshake completes.
REQ-030 SHALL ignore mem_data in all cycles other than the capture edge.

Reset
REQ-031 SHALL, while rst_in=1, immediately and without waiting for a clock edge: set state to IDLE, rr_ptr to 0, and drive miss_ready=0, fill_valid=0, mem_en=0, busy=0, fill_port=0, fill_pos=0 and fill_block=BLOCK_AIR.
REQ-032 SHALL, on reset mid-operation (ISSUE, WAIT or FILL), discard the in-flight miss and issue no fill for it. Late mem_data for that miss SHALL have no effect.
REQ-033 SHALL grant nothing during reset and allow its first grant in the first IDLE cycle after rst_in deasserts.

Verification
REQ-034 SHALL be verified by a single in-range miss: port 2 requests (3,1,0) with W=16 and mem_data=5 -> mem_en for 1 cycle with mem_addr=0x013; fill_valid at grant+4 with fill_port=2, fill_pos=(3,1,0), fill_block=5.
REQ-035 SHALL be verified by an out-of-range miss: port 0 requests (-1,0,0) -> no mem_en; fill_valid at grant+1 with fill_block=BLOCK_AIR. Repeat for (16,0,0).
REQ-036 SHALL be verified by round-robin: all 4 ports held valid from reset -> grant order 0,1,2,3,0,...; no port starves.
REQ-037 SHALL be verified by back-pressure: fill_ready held 0 for 5 cycles -> fill outputs stable and no new grant; grant follows the cycle after fill_ready=1.
REQ-038 SHALL be verified by reset in WAIT: rst_in pulsed mid-WAIT -> outputs clear asynchronously; no fill for the aborted miss; rr_ptr=0 on resume.
